rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-back scheduler and scoreboard for the 16x16 register file. It arbitrates the single register-file write port between the ALU and memory-load result sources. It also tracks pending destination registers so that issue logic stalls on RAW/WAW hazards. It sits between execute/memory stages and the register file's DstReg/DstData/WriteReg inputs.

## Interface
- DATA_W, 16, data width of a write-back result
- REG_W, 4, register index width (NUM_REGS = 2**REG_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue stage wants to reserve a destination
- iss_dst  in  REG_W  destination register to reserve
- iss_src1, iss_src2  in  REG_W  source registers of the issuing instruction
- iss_stall  out  1  combinational: busy[iss_src1] | busy[iss_src2] | busy[iss_dst]
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_reg, alu_data  in  REG_W, DATA_W  ALU destination and result
- mem_valid / mem_ready  in / out  1  load result handshake
- mem_reg, mem_data  in  REG_W, DATA_W  load destination and result
- rf_we  out  1  register-file write enable (registered)
- rf_dst  out  REG_W  register-file write index (registered)
- rf_data  out  DATA_W  register-file write data (registered)
- busy  out  NUM_REGS  scoreboard, bit i set = write to Ri pending
- err_unreserved  out  1  sticky: a write-back targeted a non-busy register

## Operation
- Reservation: iss_valid & !iss_stall sets busy[iss_dst] at the clock edge.
- Sources: each source has a one-entry slot (valid, reg, data).
  - A transfer happens when valid & ready.
  - ready = slot empty, or slot granted this cycle. This gives 1 result/cycle per source when uncontested.
- Arbitration: the grant goes to the only full slot. When both are full, it goes round-robin.
  - Pointer rr_last records the last winner; the other source wins a tie.
  - rr_last resets to MEM, so the ALU wins the first tie.
- Grant: the granted entry loads rf_we=1, rf_dst, rf_data at the next edge and clears busy[reg] at that same edge. With no grant, rf_we=0 next cycle and rf_dst/rf_data hold.
- Simultaneous set and clear of the same bit: set wins. This is unreachable through the handshake because stall covers iss_dst, but the implementation must still honour it.
- Granted write to a register whose busy bit is 0: the write still proceeds and err_unreserved sets. It clears only on reset.
- Reset (asynchronous, any cycle, mid-transfer included):
  - slots empty, busy=0, rf_we=0, rf_dst=0, rf_data=0, err_unreserved=0, rr_last=MEM.
  - In-flight results are discarded.
  - alu_ready and mem_ready read 1 immediately after reset.

## Timing
- Result accepted at edge N, slot full in cycle N+1, rf_we=1 in cycle N+2, and the RF is written at the end of N+2. Latency is 2 cycles uncontested.
- busy[reg] falls at the start of N+2. A dependent instruction issues in N+2 and reads correct data because the register file forwards DstData on a same-cycle read.
- Contended: the loser waits one cycle per competing grant. The loser's ready stays low until its slot is granted.
- Reservation at edge M: iss_stall for readers of that register is high from cycle M+1.
- iss_stall is combinational from busy and the iss_* inputs, with no dependency on the *_valid inputs.

## Configuration
- RF_ZERO_REG_EN defined:
  - Register 0 is hard-wired zero. A granted write to R0 consumes the slot, but rf_we stays 0 for that cycle and err_unreserved is not checked.
  - busy[0] never sets, and stall ignores index 0.
- RF_ZERO_REG_EN undefined: R0 behaves like every other register.

## Structure
- Shared package rf_pkg holds:
  - REG_W, DATA_W, NUM_REGS
  - typedef wb_entry_t {reg, data}
  - enum wb_src_e {SRC_ALU, SRC_MEM}
- Sub-module rf_wb_slot is the one-entry buffer with valid/ready, entry output and a grant input. It is instantiated twice.
- Scoreboard, arbiter and output register live in the top module.

## Test plan
- Reset: assert rst=0 mid-transfer with both slots full → next cycle busy=0, rf_we=0, both ready=1, err_unreserved=0.
- Single path: reserve R3, then ALU writes R3=0x1234 at edge N → rf_we=1, rf_dst=3, rf_data=0x1234 in cycle N+2, and busy[3] is 0 in that cycle.
- Contention: reserve R1 and R2, ALU(R1=0xAAAA) and MEM(R2=0x5555) accepted at the same edge → ALU written first, MEM next cycle. The next tie goes to MEM.
- Hazard: reserve R5, then present iss_src1=5 → iss_stall=1 until the cycle in which rf_we writes R5.
- Unreserved write: MEM writes R7 with busy[7]=0 → write occurs, err_unreserved=1 and stays set.
- RF_ZERO_REG_EN: reserve R0 → busy stays 0. ALU writes R0=0xFFFF → rf_we stays 0 and alu_ready stays 1.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared widths and types for the register-file write-back path.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 2 ** REG_W;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_slot.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_slot
// Brief    : One-entry result buffer; accepts a new result in the cycle it is
//            granted, so an uncontested source sustains one result per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_slot
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_valid,
    output logic      o_ready,
    input  wb_entry_t i_entry,
    input  logic      i_grant,
    output logic      o_full,
    output wb_entry_t o_entry
);

    logic      r_full;
    wb_entry_t r_entry;
    logic      w_ready;

    assign w_ready = !r_full || i_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_valid && w_ready) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (i_grant) begin
            r_full  <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Brief    : Arbitrates ALU/load results onto the RF write port and keeps the
//            pending-destination scoreboard. Option macro: RF_ZERO_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [REG_W-1:0]    iss_dst,
    input  logic [REG_W-1:0]    iss_src1,
    input  logic [REG_W-1:0]    iss_src2,
    output logic                iss_stall,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_we,
    output logic [REG_W-1:0]    rf_dst,
    output logic [DATA_W-1:0]   rf_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                err_unreserved
);

    wb_entry_t w_aluEntry, w_memEntry, w_win;
    logic      w_aluFull, w_memFull, w_grantAlu, w_grantMem, w_anyGrant;
    logic      w_winZero, w_write;
    logic [NUM_REGS-1:0] w_busyView, w_set, w_clr;

    logic [NUM_REGS-1:0] r_busy;
    logic                r_rfWe, r_err;
    logic [REG_W-1:0]    r_rfDst;
    logic [DATA_W-1:0]   r_rfData;
    wb_src_e             r_rrLast;

    rf_wb_slot u_aluSlot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (alu_valid),
        .o_ready (alu_ready),
        .i_entry ({alu_reg, alu_data}),
        .i_grant (w_grantAlu),
        .o_full  (w_aluFull),
        .o_entry (w_aluEntry)
    );

    rf_wb_slot u_memSlot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mem_valid),
        .o_ready (mem_ready),
        .i_entry ({mem_reg, mem_data}),
        .i_grant (w_grantMem),
        .o_full  (w_memFull),
        .o_entry (w_memEntry)
    );

    // The pointer only moves on ties, so a lone grant does not steal a turn.
    assign w_grantAlu = w_aluFull && (!w_memFull || r_rrLast == SRC_MEM);
    assign w_grantMem = w_memFull && (!w_aluFull || r_rrLast == SRC_ALU);
    assign w_anyGrant = w_grantAlu || w_grantMem;
    assign w_win      = w_grantMem ? w_memEntry : w_aluEntry;

`ifdef RF_ZERO_REG_EN
    assign w_winZero = (w_win.dst == '0);
`else
    assign w_winZero = 1'b0;
`endif
    assign w_write = w_anyGrant && !w_winZero;

    always_comb begin
        w_busyView = r_busy;
`ifdef RF_ZERO_REG_EN
        w_busyView[0] = 1'b0;
`endif
    end

    assign iss_stall = w_busyView[iss_src1] | w_busyView[iss_src2] | w_busyView[iss_dst];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_valid && !iss_stall) begin
            w_set[iss_dst] = 1'b1;
        end
`ifdef RF_ZERO_REG_EN
        w_set[0] = 1'b0;
`endif
        if (w_anyGrant) begin
            w_clr[w_win.dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy   <= '0;
            r_rfWe   <= 1'b0;
            r_rfDst  <= '0;
            r_rfData <= '0;
            r_err    <= 1'b0;
            r_rrLast <= SRC_MEM;
        end else begin
            // Set is applied after clear so a same-cycle reservation wins.
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_rfWe <= w_write;
            if (w_write) begin
                r_rfDst  <= w_win.dst;
                r_rfData <= w_win.data;
                if (!r_busy[w_win.dst]) begin
                    r_err <= 1'b1;
                end
            end
            if (w_aluFull && w_memFull) begin
                r_rrLast <= w_grantAlu ? SRC_ALU : SRC_MEM;
            end
        end
    end

    assign busy           = r_busy;
    assign rf_we          = r_rfWe;
    assign rf_dst         = r_rfDst;
    assign rf_data        = r_rfData;
    assign err_unreserved = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scheduler
// Brief    : Directed self-checking bench with a write-back scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;
    import rf_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                iss_valid = 1'b0;
    logic [REG_W-1:0]    iss_dst = '0, iss_src1 = '0, iss_src2 = '0;
    logic                iss_stall;
    logic                alu_valid = 1'b0, alu_ready;
    logic [REG_W-1:0]    alu_reg = '0;
    logic [DATA_W-1:0]   alu_data = '0;
    logic                mem_valid = 1'b0, mem_ready;
    logic [REG_W-1:0]    mem_reg = '0;
    logic [DATA_W-1:0]   mem_data = '0;
    logic                rf_we;
    logic [REG_W-1:0]    rf_dst;
    logic [DATA_W-1:0]   rf_data;
    logic [NUM_REGS-1:0] busy;
    logic                err_unreserved;

    int nCmp  = 0;
    int nFail = 0;
    logic [REG_W+DATA_W-1:0] sb[$];

    rf_wb_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .iss_valid      (iss_valid),
        .iss_dst        (iss_dst),
        .iss_src1       (iss_src1),
        .iss_src2       (iss_src2),
        .iss_stall      (iss_stall),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .rf_we          (rf_we),
        .rf_dst         (rf_dst),
        .rf_data        (rf_data),
        .busy           (busy),
        .err_unreserved (err_unreserved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any write-back seen must match the scoreboard head.
    task automatic tick();
        logic [REG_W+DATA_W-1:0] exp;
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) begin
            nCmp++;
            assert (sb.size() != 0) else begin
                nFail++;
                $error("FAIL unexpected_wb: observed dst %0h data %0h expected no write", rf_dst, rf_data);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("wb", 32'({rf_dst, rf_data}), 32'(exp));
            end
        end
    endtask

    task automatic reserve(input logic [REG_W-1:0] r);
        iss_valid = 1'b1;
        iss_dst   = r;
        tick();
        iss_valid = 1'b0;
        iss_dst   = '0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_we", 32'(rf_we), 32'h0);
        check("rst_ready", 32'({alu_ready, mem_ready}), 32'h3);
        check("rst_err", 32'(err_unreserved), 32'h0);

        // Single path: reserve R3, ALU writes R3 = 0x1234
        iss_valid = 1'b1; iss_dst = 4'd3; iss_src1 = 4'd3; iss_src2 = 4'd3;
        tick();
        check("rsv_busy3", 32'(busy), 32'h0008);
        check("rsv_stall3", 32'(iss_stall), 32'h1);
        iss_valid = 1'b0; iss_dst = '0; iss_src1 = '0; iss_src2 = '0;
        alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234;
        check("alu_ready_idle", 32'(alu_ready), 32'h1);
        sb.push_back({4'd3, 16'h1234});
        tick();
        alu_valid = 1'b0;
        check("lat_n1_we", 32'(rf_we), 32'h0);
        check("lat_n1_busy", 32'(busy), 32'h0008);
        tick();
        check("lat_n2_we", 32'(rf_we), 32'h1);
        check("lat_n2_busy", 32'(busy), 32'h0);

        // Hazard: R5 reserved, reader stalls until the write cycle
        reserve(4'd5);
        iss_src1 = 4'd5;
        check("haz_stall0", 32'(iss_stall), 32'h1);
        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'h0BEE;
        sb.push_back({4'd5, 16'h0BEE});
        tick();
        mem_valid = 1'b0;
        check("haz_stall1", 32'(iss_stall), 32'h1);
        tick();
        check("haz_we", 32'(rf_we), 32'h1);
        check("haz_stall2", 32'(iss_stall), 32'h0);
        iss_src1 = '0;

        // Contention: first tie to ALU
        reserve(4'd1);
        reserve(4'd2);
        check("cont_busy", 32'(busy), 32'h0006);
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'h5555;
        sb.push_back({4'd1, 16'hAAAA});
        sb.push_back({4'd2, 16'h5555});
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("tie1_ready", 32'({alu_ready, mem_ready}), 32'h2);
        tick();
        check("tie1_memready", 32'(mem_ready), 32'h1);
        tick();
        check("tie1_busy", 32'(busy), 32'h0);

        // Second tie goes to MEM
        reserve(4'd1);
        reserve(4'd2);
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'h2222;
        sb.push_back({4'd2, 16'h2222});
        sb.push_back({4'd1, 16'h1111});
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("tie2_ready", 32'({alu_ready, mem_ready}), 32'h1);
        tick();
        tick();
        check("tie2_busy", 32'(busy), 32'h0);

        // Unreserved write to R7
        check("err_before", 32'(err_unreserved), 32'h0);
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'h7777;
        sb.push_back({4'd7, 16'h7777});
        tick();
        mem_valid = 1'b0;
        tick();
        check("err_set", 32'(err_unreserved), 32'h1);
        repeat (3) tick();
        check("err_sticky", 32'(err_unreserved), 32'h1);

        // Asynchronous reset with both slots full
        reserve(4'd4);
        reserve(4'd6);
        alu_valid = 1'b1; alu_reg = 4'd4; alu_data = 16'h4444;
        mem_valid = 1'b1; mem_reg = 4'd6; mem_data = 16'h6666;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("pre_rst_full", 32'({alu_ready, mem_ready}), 32'h2);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_we", 32'(rf_we), 32'h0);
        check("arst_ready", 32'({alu_ready, mem_ready}), 32'h3);
        check("arst_err", 32'(err_unreserved), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_we", 32'(rf_we), 32'h0);

`ifdef RF_ZERO_REG_EN
        reserve(4'd0);
        check("z_busy", 32'(busy), 32'h0);
        alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 16'hFFFF;
        check("z_ready0", 32'(alu_ready), 32'h1);
        tick();
        alu_valid = 1'b0;
        check("z_ready1", 32'(alu_ready), 32'h1);
        tick();
        check("z_we", 32'(rf_we), 32'h0);
        check("z_err", 32'(err_unreserved), 32'h0);
`else
        reserve(4'd0);
        check("r0_busy", 32'(busy), 32'h0001);
        alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 16'hFFFF;
        sb.push_back({4'd0, 16'hFFFF});
        tick();
        alu_valid = 1'b0;
        tick();
        check("r0_we", 32'(rf_we), 32'h1);
        check("r0_busy_clr", 32'(busy), 32'h0);
`endif

        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
